// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants, request kinds and loader FSM states.
// Used by the instruction encoder, the main decoder and the benches.
package rv_isa_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;

    typedef enum logic [1:0] {
        KIND_LW    = 2'b00,
        KIND_SW    = 2'b01,
        KIND_RTYPE = 2'b10,
        KIND_BEQ   = 2'b11
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCEPT = 2'b01,
        ST_WRITE  = 2'b10
    } state_e;

    // A 13-bit immediate fits the 12-bit I/S field when its top two bits agree.
    function automatic logic imm_fits_12(input logic [12:0] imm);
        return (imm[12] == imm[11]);
    endfunction

endpackage

// File: rtl/rv_instr_encoder_if.sv
// Request handshake and instruction-memory write port of the encoder.
interface rv_instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_kind;
    logic [3:0]        req_funct;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [12:0]       req_imm;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output req_valid, req_kind, req_funct, req_rd, req_rs1, req_rs2, req_imm,
        output mem_ready,
        input  req_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_kind, req_funct, req_rd, req_rs1, req_rs2, req_imm,
        input  mem_ready,
        output req_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rv_instr_pack.sv
// Combinational packer: symbolic request -> 32-bit RV32I word plus legality flag.
module rv_instr_pack
    import rv_isa_pkg::*;
(
    input  logic [1:0]  i_kind,
    input  logic [3:0]  i_funct,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [12:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_legal
);

    // Field packing per request kind; funct[3] selects funct7[5] (SUB only).
    always_comb begin
        o_word  = 32'h0000_0000;
        o_legal = 1'b0;
        case (i_kind)
            KIND_LW: begin
                o_word  = {i_imm[11:0], i_rs1, F3_LW, i_rd, OP_LOAD};
                o_legal = imm_fits_12(i_imm);
            end
            KIND_SW: begin
                o_word  = {i_imm[11:5], i_rs2, i_rs1, F3_SW, i_imm[4:0], OP_STORE};
                o_legal = imm_fits_12(i_imm);
            end
            KIND_RTYPE: begin
                o_word  = {1'b0, i_funct[3], 5'b00000, i_rs2, i_rs1, i_funct[2:0], i_rd, OP_RTYPE};
                o_legal = (~i_funct[3]) | (i_funct[2:0] == F3_ADD_SUB);
            end
            KIND_BEQ: begin
                o_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BEQ, i_imm[4:1], i_imm[11], OP_BRANCH};
                o_legal = ~i_imm[0];
            end
            default: begin
                o_word  = 32'h0000_0000;
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv_instr_encoder.sv
// Sequential instruction loader: accepts symbolic requests, packs them and
// writes the words to consecutive instruction-memory addresses from BASE_ADDR.
module rv_instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    rv_instr_encoder_if.slave bus,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_count_nxt;
    logic [ADDR_W:0]   w_count_inc;
    logic              r_full;
    logic              w_full_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic              r_stop_seen;
    logic              w_stop_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [31:0]       r_wdata;
    logic [31:0]       w_wdata_nxt;
    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_req_ready;
    logic              w_fire;

    rv_instr_pack u_pack (
        .i_kind  (bus.req_kind),
        .i_funct (bus.req_funct),
        .i_rd    (bus.req_rd),
        .i_rs1   (bus.req_rs1),
        .i_rs2   (bus.req_rs2),
        .i_imm   (bus.req_imm),
        .o_word  (w_word),
        .o_legal (w_legal)
    );

    assign w_req_ready = (r_state == ST_ACCEPT) && !r_full;
    assign w_fire      = w_req_ready && bus.req_valid;
    assign w_count_inc = r_count + {{ADDR_W{1'b0}}, 1'b1};

    // Next-state and next-output logic; start overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_full_nxt  = r_full;
        w_err_nxt   = r_err;
        w_we_nxt    = r_we;
        w_stop_nxt  = r_stop_seen;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        if (start) begin
            w_state_nxt = ST_ACCEPT;
            w_count_nxt = '0;
            w_full_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
            w_we_nxt    = 1'b0;
            w_stop_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_we_nxt   = 1'b0;
                    w_stop_nxt = 1'b0;
                end
                ST_ACCEPT: begin
                    // A request accepted together with stop is still written.
                    if (w_fire && w_legal) begin
                        w_addr_nxt  = BASE + r_count[ADDR_W-1:0];
                        w_wdata_nxt = w_word;
                        w_we_nxt    = 1'b1;
                        w_stop_nxt  = stop;
                        w_state_nxt = ST_WRITE;
                    end else if (w_fire) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = stop ? ST_IDLE : ST_ACCEPT;
                    end else if (stop) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ACCEPT;
                    end
                end
                ST_WRITE: begin
                    if (bus.mem_ready) begin
                        w_count_nxt = w_count_inc;
                        w_full_nxt  = (w_count_inc == CAPACITY);
                        w_we_nxt    = 1'b0;
                        w_stop_nxt  = 1'b0;
                        w_state_nxt = (r_stop_seen || stop) ? ST_IDLE : ST_ACCEPT;
                    end else begin
                        w_stop_nxt  = r_stop_seen || stop;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_we_nxt    = 1'b0;
                    w_stop_nxt  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_err       <= 1'b0;
            r_we        <= 1'b0;
            r_stop_seen <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'h0000_0000;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_full      <= w_full_nxt;
            r_err       <= w_err_nxt;
            r_we        <= w_we_nxt;
            r_stop_seen <= w_stop_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign count         = r_count;
    assign full          = r_full;
    assign err           = r_err;

endmodule
